// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op/class codes and divider state encoding for the MIPS execute stage.
package ex_stage_pkg;

    localparam int REG_W    = 32;
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_LUI_OP   = 8'b0101_1100;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALUOP_W-1:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;

    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP         = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH       = 3'b100;
    localparam logic [ALUSEL_W-1:0] EXE_RES_JUMP_BRANCH = 3'b110;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    function automatic logic [REG_W-1:0] neg_if(input logic neg, input logic [REG_W-1:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider: one quotient bit per cycle, busy (stall) while latching and iterating,
// done pulses for one cycle with sign-corrected results; abort returns to IDLE without a result.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [REG_W-1:0] dividend,
    input  logic [REG_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] quotient,
    output logic [REG_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [REG_W-1:0] quo, rem, dvs;
    logic             neg_q, neg_r;
    logic [REG_W:0]   partial, diff;

    assign partial = {rem, quo[REG_W-1]};
    assign diff    = partial - {1'b0, dvs};

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        if (abort) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        busy      = 1'b1;
                        state_nxt = (divisor == '0) ? DIV_DONE : DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    busy = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    done      = 1'b1;
                    state_nxt = DIV_IDLE;
                end
                default: state_nxt = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Divide-by-zero preloads the architectural result and clears the sign flags so fix-up is a no-op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (!abort) begin
            if (state == DIV_IDLE && start) begin
                cnt <= '0;
                if (divisor == '0) begin
                    quo   <= '1;
                    rem   <= dividend;
                    dvs   <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    quo   <= neg_if(is_signed & dividend[REG_W-1], dividend);
                    rem   <= '0;
                    dvs   <= neg_if(is_signed & divisor[REG_W-1], divisor);
                    neg_q <= is_signed & (dividend[REG_W-1] ^ divisor[REG_W-1]);
                    neg_r <= is_signed & dividend[REG_W-1];
                end
            end else if (state == DIV_BUSY) begin
                cnt <= cnt + CNT_W'(1);
                if (!diff[REG_W]) begin
                    rem <= diff[REG_W-1:0];
                    quo <= {quo[REG_W-2:0], 1'b1};
                end else begin
                    rem <= partial[REG_W-1:0];
                    quo <= {quo[REG_W-2:0], 1'b0};
                end
            end
        end
    end

    assign quotient  = neg_if(neg_q, quo);
    assign remainder = neg_if(neg_r, rem);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU result, HI/LO updated at the clock edge, DIV/DIVU stalls upstream 33 cycles via stallreq_o.
// EX_OVF_TRAP_EN adds ovf_o and suppresses the register write on ADD/ADDI/SUB signed overflow.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [REG_W-1:0]    reg1_i,
    input  logic [REG_W-1:0]    reg2_i,
    input  logic [4:0]          wd_i,
    input  logic                wreg_i,
    input  logic [REG_W-1:0]    return_addr_i,
    input  logic [REG_W-1:0]    inst_i,
    input  logic [REG_W-1:0]    pc_i,
    input  logic                flush_i,
    output logic [4:0]          wd_o,
    output logic                wreg_o,
    output logic [REG_W-1:0]    wdata_o,
    output logic [REG_W-1:0]    inst_o,
    output logic [REG_W-1:0]    pc_o,
    output logic                stallreq_o,
`ifdef EX_OVF_TRAP_EN
    output logic                ovf_o,
`endif
    output logic [REG_W-1:0]    hi_o,
    output logic [REG_W-1:0]    lo_o
);

    logic [REG_W-1:0]   hi, lo;
    logic [REG_W-1:0]   logic_res, shift_res, arith_res, move_res;
    logic [REG_W-1:0]   b_eff, sum;
    logic               is_sub, mul_signed;
    logic [2*REG_W-1:0] mul_a, mul_b, product;
    logic               div_start, div_signed, div_done;
    logic [REG_W-1:0]   div_quo, div_rem;
    logic [4:0]         shamt;

    assign is_sub  = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
    assign b_eff   = is_sub ? (~reg2_i + 32'd1) : reg2_i;
    assign sum     = reg1_i + b_eff;
    assign shamt   = reg1_i[4:0];

    assign mul_signed = (aluop_i == EXE_MULT_OP);
    assign mul_a      = {{REG_W{mul_signed & reg1_i[REG_W-1]}}, reg1_i};
    assign mul_b      = {{REG_W{mul_signed & reg2_i[REG_W-1]}}, reg2_i};
    assign product    = mul_a * mul_b;

    assign div_start  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign div_signed = (aluop_i == EXE_DIV_OP);

    div_iter #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush_i),
        .is_signed (div_signed),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .busy      (stallreq_o),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            EXE_LUI_OP: logic_res = {reg2_i[15:0], 16'h0000};
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << shamt;
            EXE_SRL_OP: shift_res = reg2_i >> shamt;
            EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> shamt);
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_i)
            EXE_SLT_OP:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {31'b0, reg1_i < reg2_i};
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
            default:     arith_res = '0;
        endcase
    end

    always_comb begin
        move_res = '0;
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi;
            EXE_MFLO_OP: move_res = lo;
            default:     move_res = '0;
        endcase
    end

    always_comb begin
        wdata_o = '0;
        case (alusel_i)
            EXE_RES_LOGIC:       wdata_o = logic_res;
            EXE_RES_SHIFT:       wdata_o = shift_res;
            EXE_RES_ARITH:       wdata_o = arith_res;
            EXE_RES_MOVE:        wdata_o = move_res;
            EXE_RES_JUMP_BRANCH: wdata_o = return_addr_i;
            default:             wdata_o = '0;
        endcase
    end

    // Writes land at the end of the cycle, so a following MFHI/MFLO reads the register directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done) begin
            hi <= div_rem;
            lo <= div_quo;
        end else begin
            case (aluop_i)
                EXE_MULT_OP, EXE_MULTU_OP: begin
                    hi <= product[2*REG_W-1:REG_W];
                    lo <= product[REG_W-1:0];
                end
                EXE_MTHI_OP: hi <= reg1_i;
                EXE_MTLO_OP: lo <= reg1_i;
                default: ;
            endcase
        end
    end

`ifdef EX_OVF_TRAP_EN
    logic ovf_raw, trap_op;
    // Subtraction overflows when operand signs differ; addition when they match; either way the sum sign flips.
    assign ovf_raw = is_sub ? ((reg1_i[REG_W-1] != reg2_i[REG_W-1]) && (sum[REG_W-1] != reg1_i[REG_W-1]))
                            : ((reg1_i[REG_W-1] == reg2_i[REG_W-1]) && (sum[REG_W-1] != reg1_i[REG_W-1]));
    assign trap_op = (aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP) || (aluop_i == EXE_SUB_OP);
    assign ovf_o   = trap_op & ovf_raw;
    assign wreg_o  = wreg_i & ~ovf_o;
`else
    assign wreg_o  = wreg_i;
`endif

    assign wd_o   = wd_i;
    assign inst_o = inst_i;
    assign pc_o   = pc_i;
    assign hi_o   = hi;
    assign lo_o   = lo;

endmodule
